// File: rtl/eth_tx_arb2.sv
// Two-port frame-atomic AXI-Stream arbiter for the MAC TX path.
// Grants whole frames (round-robin or fixed priority) and truncates oversize frames as bad.
module eth_tx_arb2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ROUND_ROBIN   = 1,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tuser,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  frame_cnt0,
    output logic [CNT_WIDTH-1:0]  frame_cnt1,
    output logic [7:0]            trunc_cnt
);
    localparam int BW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                state, state_nxt;
    logic                  gsel, gsel_nxt;
    logic                  last, last_nxt;
    logic [BW-1:0]         beat_cnt;
    logic                  out_port;
    logic                  out_ready;
    logic                  acc, trunc;
    logic                  sel_valid, sel_last, sel_user;
    logic [DATA_WIDTH-1:0] sel_data;

    assign sel_valid = gsel ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = gsel ? s1_axis_tlast  : s0_axis_tlast;
    assign sel_user  = gsel ? s1_axis_tuser  : s0_axis_tuser;
    assign sel_data  = gsel ? s1_axis_tdata  : s0_axis_tdata;
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign grant     = (state == IDLE) ? 2'b00 : (gsel ? 2'b10 : 2'b01);

    always_comb begin
        state_nxt      = state;
        gsel_nxt       = gsel;
        last_nxt       = last;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        acc            = 1'b0;
        trunc          = 1'b0;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    state_nxt = PASS;
                    if (s0_axis_tvalid && s1_axis_tvalid)
                        gsel_nxt = (ROUND_ROBIN != 0) ? !last : 1'b0;
                    else
                        gsel_nxt = s1_axis_tvalid;
                end
            end
            PASS: begin
                s0_axis_tready = !gsel && out_ready;
                s1_axis_tready = gsel && out_ready;
                acc            = sel_valid && out_ready;
                if (acc) begin
                    if (sel_last) begin
                        state_nxt = IDLE;
                        last_nxt  = gsel;
                    end else if (beat_cnt == LAST_BEAT) begin
                        trunc     = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                // Swallow the remainder of an oversize frame up to its real tlast.
                s0_axis_tready = !gsel;
                s1_axis_tready = gsel;
                if (sel_valid && sel_last) begin
                    state_nxt = IDLE;
                    last_nxt  = gsel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gsel          <= 1'b0;
            last          <= 1'b1;
            beat_cnt      <= '0;
            out_port      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_cnt0    <= '0;
            frame_cnt1    <= '0;
            trunc_cnt     <= '0;
        end else begin
            state <= state_nxt;
            gsel  <= gsel_nxt;
            last  <= last_nxt;
            if (acc) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tlast  <= sel_last || trunc;
                m_axis_tuser  <= sel_user || trunc;
                out_port      <= gsel;
                beat_cnt      <= (sel_last || trunc) ? '0 : beat_cnt + 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (trunc && trunc_cnt != 8'hFF)
                trunc_cnt <= trunc_cnt + 1'b1;
            // Credit the port that produced the beat, since gsel may already have moved on.
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                if (out_port)
                    frame_cnt1 <= frame_cnt1 + 1'b1;
                else
                    frame_cnt0 <= frame_cnt0 + 1'b1;
            end
        end
    end
endmodule
